// File: rtl/trng_pkg.sv
// Shared types and default sizing for the ring-oscillator entropy capture buffer.
package trng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_e;

    localparam int SYNC_STAGES    = 2;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_CH_SEL_W   = 2;
    localparam int DEF_WORD_W     = 32;
    localparam int DEF_DEPTH      = 256;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DECIM_W    = 8;
    localparam int DEF_RCT_CUTOFF = 32;

endpackage

// File: rtl/trng_capture_buffer_if.sv
// Control, status and readout bundle of the entropy capture buffer; slave = buffer, master = host.
interface trng_capture_buffer_if
    import trng_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CH_SEL_W = DEF_CH_SEL_W,
    parameter int WORD_W   = DEF_WORD_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DECIM_W  = DEF_DECIM_W
);
    logic [NUM_CH-1:0]   raw_bits_i;
    logic [CH_SEL_W-1:0] ch_sel_i;
    logic                xor_mode_i;
    logic [DECIM_W-1:0]  decim_i;
    logic                continuous_i;
    logic                start_i;
    logic                stop_i;
    logic                busy_o;
    logic                done_o;
    logic                wrapped_o;
    logic [ADDR_W:0]     word_count_o;
    logic                rd_en_i;
    logic [ADDR_W-1:0]   rd_addr_i;
    logic [WORD_W-1:0]   rd_data_o;
    logic                rd_valid_o;
    logic                health_fail_o;

    modport slave (
        input  raw_bits_i, ch_sel_i, xor_mode_i, decim_i, continuous_i, start_i, stop_i,
               rd_en_i, rd_addr_i,
        output busy_o, done_o, wrapped_o, word_count_o, rd_data_o, rd_valid_o, health_fail_o
    );

    modport master (
        output raw_bits_i, ch_sel_i, xor_mode_i, decim_i, continuous_i, start_i, stop_i,
               rd_en_i, rd_addr_i,
        input  busy_o, done_o, wrapped_o, word_count_o, rd_data_o, rd_valid_o, health_fail_o
    );

endinterface

// File: rtl/trng_sync2.sv
// Single-lane synchroniser bringing an asynchronous oscillator bit into the clk domain.
module trng_sync2
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trng_capture_buffer.sv
// Entropy capture buffer: sync, select, decimate, pack and store oscillator samples.
// Optional repetition-count health test is built when TRNG_HEALTH_EN is defined.
module trng_capture_buffer
    import trng_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CH_SEL_W   = DEF_CH_SEL_W,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DECIM_W    = DEF_DECIM_W,
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
    input logic                  clk,
    input logic                  rst,
    trng_capture_buffer_if.slave bus
);
    localparam int                BIT_W      = $clog2(WORD_W);
    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [NUM_CH-1:0]   sync_bits;
    cap_state_e          state_q;
    logic [CH_SEL_W-1:0] ch_q;
    logic                xor_q, cont_q;
    logic [DECIM_W-1:0]  decim_q, dec_cnt_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                busy_q, done_q, wrapped_q;
    logic [WORD_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic [CH_SEL_W-1:0] ch_eff;
    logic                sample, accept, start_acc, wr_en;
    logic [WORD_W-1:0]   mem [DEPTH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        trng_sync2 u_sync (.clk(clk), .rst(rst), .d_i(bus.raw_bits_i[g]), .q_o(sync_bits[g]));
    end

    // NOTE: combinational logic uses blocking '=' and assigns every output first, so no latch can form.
    always_comb begin
        ch_eff       = (int'(bus.ch_sel_i) >= NUM_CH) ? '0 : bus.ch_sel_i;
        sample       = xor_q ? (^sync_bits) : sync_bits[ch_q];
        accept       = (state_q == CAPTURE) && (dec_cnt_q == '0);
        start_acc    = bus.start_i && (state_q != CAPTURE);
        shift_d      = {sample, shift_q[WORD_W-1:1]};
        wr_en        = accept && (bit_cnt_q == LAST_BIT);
        word_count_d = (word_count_q == FULL_COUNT) ? word_count_q : word_count_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            xor_q        <= 1'b0;
            cont_q       <= 1'b0;
            decim_q      <= '0;
            dec_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wrapped_q    <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en_i;
            if (bus.rd_en_i) rd_data_q <= mem[bus.rd_addr_i];

            case (state_q)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        ch_q         <= ch_eff;
                        xor_q        <= bus.xor_mode_i;
                        cont_q       <= bus.continuous_i;
                        decim_q      <= bus.decim_i;
                        dec_cnt_q    <= bus.decim_i;
                        bit_cnt_q    <= '0;
                        wr_ptr_q     <= '0;
                        word_count_q <= '0;
                        wrapped_q    <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        state_q      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (accept) begin
                        dec_cnt_q <= decim_q;
                        shift_q   <= shift_d;
                        bit_cnt_q <= wr_en ? '0 : bit_cnt_q + 1'b1;
                    end else begin
                        dec_cnt_q <= dec_cnt_q - 1'b1;
                    end
                    if (wr_en) begin
                        wr_ptr_q     <= wr_ptr_q + 1'b1;
                        word_count_q <= word_count_d;
                        if (cont_q && wr_ptr_q == LAST_ADDR) wrapped_q <= 1'b1;
                    end
                    // A word completing alongside stop is still stored before DONE.
                    if (bus.stop_i || (wr_en && !cont_q && wr_ptr_q == LAST_ADDR)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the sample buffer has no reset; contents survive reset and only writes change them.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= shift_d;
    end

`ifdef TRNG_HEALTH_EN
    localparam int              RUN_W   = $clog2(RCT_CUTOFF + 1);
    localparam logic [RUN_W-1:0] RUN_CUT = RUN_W'(RCT_CUTOFF);

    logic [RUN_W-1:0] run_q, run_d;
    logic             prev_q, first_q, health_q;

    always_comb begin
        if (first_q || sample != prev_q) run_d = RUN_W'(1);
        else if (run_q == RUN_CUT)       run_d = run_q;
        else                             run_d = run_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q    <= '0;
            prev_q   <= 1'b0;
            first_q  <= 1'b1;
            health_q <= 1'b0;
        end else if (start_acc) begin
            run_q    <= '0;
            first_q  <= 1'b1;
            health_q <= 1'b0;
        end else if (accept) begin
            run_q   <= run_d;
            prev_q  <= sample;
            first_q <= 1'b0;
            if (run_d == RUN_CUT) health_q <= 1'b1;
        end
    end

    assign bus.health_fail_o = health_q;
`else
    assign bus.health_fail_o = 1'b0;
`endif

    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.wrapped_o    = wrapped_q;
    assign bus.word_count_o = word_count_q;
    assign bus.rd_data_o    = rd_data_q;
    assign bus.rd_valid_o   = rd_valid_q;

endmodule
